// File: rtl/branch_cmp_seq_if.sv
// Request/response bundle for the multi-cycle branch comparator.
// The consumer side drives requests and accepts results.
interface branch_cmp_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            br_lt;
  logic            br_eq;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            illegal;

  modport master (
    output in_valid, rs1_data, rs2_data, funct3, pc, imm,
    output flush, out_ready,
    input  in_ready, out_valid, br_lt, br_eq, br_taken,
    input  br_target, illegal
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, funct3, pc, imm,
    input  flush, out_ready,
    output in_ready, out_valid, br_lt, br_eq, br_taken,
    output br_target, illegal
  );
endinterface

// File: rtl/branch_cmp_seq.sv
// Slice-serial branch comparator/resolver: MSB-first compare with
// early exit on the first differing slice, plus registered pc+imm.
module branch_cmp_seq #(
  parameter int XLEN  = 32,
  parameter int SLICE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  branch_cmp_seq_if.slave bus
);
  localparam int NSLICE = XLEN / SLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            lt_q, lt_d;
  logic            eq_q, eq_d;
  logic            tk_q, tk_d;
  logic            ill_q, ill_d;

  logic             acc;
  logic             f3_ill;
  logic [SLICE-1:0] sa, sb;

  function automatic logic taken_of(
    input logic [2:0] f3,
    input logic       lt,
    input logic       eq
  );
    logic t;
    t = 1'b0;
    unique case (1'b1)
      (f3 == 3'b000): t = eq;
      (f3 == 3'b001): t = !eq;
      (f3 == 3'b100),
      (f3 == 3'b110): t = lt;
      (f3 == 3'b101),
      (f3 == 3'b111): t = !lt;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  assign acc    = bus.in_valid && (state_q == IDLE) && !bus.flush;
  assign f3_ill = (f3_q[2:1] == 2'b01);

  // Signed compare: flip the sign bit of the top slice, then compare unsigned.
  always_comb begin
    sa = a_q[idx_q*SLICE +: SLICE];
    sb = b_q[idx_q*SLICE +: SLICE];
    if (!f3_q[1] && idx_q == TOP) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      tgt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      tk_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      tgt_q   <= tgt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      tk_q    <= tk_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    tgt_d   = tgt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    tk_d    = tk_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          a_d     = bus.rs1_data;
          b_d     = bus.rs2_data;
          f3_d    = bus.funct3;
          tgt_d   = bus.pc + bus.imm;
          idx_d   = TOP;
          state_d = CMP;
        end
      end
      CMP: begin
        if (f3_ill) begin
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          tk_d    = 1'b0;
          ill_d   = 1'b1;
          state_d = DONE;
        end else if (sa != sb) begin
          lt_d    = (sa < sb);
          eq_d    = 1'b0;
          tk_d    = taken_of(f3_q, sa < sb, 1'b0);
          ill_d   = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          tk_d    = taken_of(f3_q, 1'b0, 1'b1);
          ill_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.br_lt     = lt_q;
    bus.br_eq     = eq_q;
    bus.br_taken  = tk_q;
    bus.illegal   = ill_q;
    bus.br_target = tgt_q;
  end
endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed bench for branch_cmp_seq: vector table plus
// backpressure, flush and async-reset sequences.
module tb_branch_cmp_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  branch_cmp_seq_if #(.XLEN(32)) bus ();

  branch_cmp_seq #(.XLEN(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        lt;
    logic        eq;
    logic        tk;
    logic        ill;
    logic [31:0] tgt;
    int          lat;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_req(input vec_t t);
    bus.in_valid = 1'b1;
    bus.funct3   = t.f3;
    bus.rs1_data = t.a;
    bus.rs2_data = t.b;
    bus.pc       = t.pc;
    bus.imm      = t.imm;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_res(input vec_t t, input int lat);
    chk({t.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({t.name, " latency"}, 32'(lat), 32'(t.lat));
    chk({t.name, " lt"}, 32'(bus.br_lt), 32'(t.lt));
    chk({t.name, " eq"}, 32'(bus.br_eq), 32'(t.eq));
    chk({t.name, " taken"}, 32'(bus.br_taken), 32'(t.tk));
    chk({t.name, " illegal"}, 32'(bus.illegal), 32'(t.ill));
    chk({t.name, " target"}, bus.br_target, t.tgt);
    chk({t.name, " in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release in_ready", 32'(bus.in_ready), 32'd1);
    chk("release out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({nm, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, " lt"}, 32'(bus.br_lt), 32'd0);
    chk({nm, " eq"}, 32'(bus.br_eq), 32'd0);
    chk({nm, " taken"}, 32'(bus.br_taken), 32'd0);
    chk({nm, " illegal"}, 32'(bus.illegal), 32'd0);
    chk({nm, " target"}, bus.br_target, 32'd0);
  endtask

  task automatic no_valid_for(input string nm, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk({nm, " no out_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] hold_tgt;
    total  = 0;
    passed = 0;
    v[0]  = '{"beq_eq", 3'b000, 32'h12345678, 32'h12345678, 32'h0,
              32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4};
    v[1]  = '{"blt_neg", 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h100,
              32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h110, 1};
    v[2]  = '{"bltu", 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h100,
              32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h110, 1};
    v[3]  = '{"bgeu", 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h100,
              32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h110, 1};
    v[4]  = '{"bne", 3'b001, 32'h00000100, 32'h00000101, 32'h1000,
              32'hFFFFFFF8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0FF8, 4};
    v[5]  = '{"ill010", 3'b010, 32'h5, 32'h5, 32'h20,
              32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h24, 1};
    v[6]  = '{"beq_ne", 3'b000, 32'hAABB0000, 32'hAABB0001, 32'h40,
              32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 4};
    v[7]  = '{"bge_min", 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h0,
              32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 1};
    v[8]  = '{"blt_s2", 3'b100, 32'h00120000, 32'h00130000, 32'h10,
              32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 2};
    v[9]  = '{"bne_wrap", 3'b001, 32'h7, 32'h7, 32'hFFFFFFF0,
              32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 4};
    v[10] = '{"ill011", 3'b011, 32'h1, 32'h2, 32'h0,
              32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct3    = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.pc        = '0;
    bus.imm       = '0;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      drive_req(v[i]);
      wait_done(lat);
      check_res(v[i], lat);
      release_out();
    end

    // Backpressure: outputs frozen while out_ready low.
    drive_req(v[4]);
    wait_done(lat);
    check_res(v[4], lat);
    hold_tgt = bus.br_target;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp taken", 32'(bus.br_taken), 32'd1);
      chk("bp target", bus.br_target, hold_tgt);
    end
    release_out();

    // Flush in the second CMP cycle.
    drive_req(v[0]);
    @(posedge clk); #1;
    chk("flush pre in_ready", 32'(bus.in_ready), 32'd0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    no_valid_for("flush", 6);

    // Async reset mid-CMP, checked before the next edge.
    drive_req(v[9]);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_valid_for("async rst", 6);

    // Flush beats in_valid in IDLE.
    bus.in_valid = 1'b1;
    bus.funct3   = 3'b000;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("idle flush in_ready", 32'(bus.in_ready), 32'd1);
    no_valid_for("idle flush", 6);

    // Normal operation resumes afterwards.
    drive_req(v[8]);
    wait_done(lat);
    check_res(v[8], lat);
    release_out();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
